aes_key_sched_ctrl: RTL and testbench

Sequences AES-128 key expansion one round per cycle and holds all 11 round keys for the cipher core. It accepts a 128-bit cipher key over a valid/ready handshake and computes round keys 1..10 from round key 0. It then serves indexed, registered round-key reads to the encrypt and decrypt round engines. It sits between the key-load interface and the round datapath, and replaces per-round on-the-fly expansion.

---
 rtl/aes_key_sched_ctrl_if.sv | 45 ++++
 rtl/aes_key_sched_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl_if
// Handshake and read-port bundle for the AES-128 key schedule controller.
//
// Signals (directions given for the slave = key schedule side):
//    key_in       in  128  cipher key, [127:96] is w0
//    key_valid    in  1    key offer
//    key_ready    out 1    high only while idle; key accepted on valid && ready
//    zeroize      in  1    clear stored keys (only honoured when the
//                          AES_KEYSCHED_ZEROIZE_EN build option is set)
//    rk_rd        in  1    round-key read request
//    rk_idx       in  4    round index 0..10
//    rk_out       out 128  registered round key
//    rk_out_valid out 1    pulse: rk_out carries a read result
//    rk_err       out 1    pulse: the read was rejected
//    keys_valid   out 1    level: all 11 round keys valid
//    busy         out 1    expansion in progress (EXPAND or DONE)
//    done         out 1    pulse: expansion complete
// -----------------------------------------------------------------------------
interface aes_key_sched_ctrl_if;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic         zeroize;
   logic         rk_rd;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;
   logic         rk_out_valid;
   logic         rk_err;
   logic         keys_valid;
   logic         busy;
   logic         done;

   // Key loader / round engine side
   modport master (
      output key_in, key_valid, zeroize, rk_rd, rk_idx,
      input  key_ready, rk_out, rk_out_valid, rk_err, keys_valid, busy, done
   );

   // Key schedule side
   modport slave (
      input  key_in, key_valid, zeroize, rk_rd, rk_idx,
      output key_ready, rk_out, rk_out_valid, rk_err, keys_valid, busy, done
   );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
// AES-128 key expansion, one round key per cycle, holding all 11 round keys
// and serving registered indexed reads to the round engines.
//
// Ports:
//    clk    in   rising-edge clock
//    reset  in   synchronous, active-low reset
//    bus    slave modport of aes_key_sched_ctrl_if (key handshake, zeroize,
//           round-key read port, status)
//
// Build option:
//    AES_KEYSCHED_ZEROIZE_EN  when defined, zeroize clears all stored keys,
//                             the read register and aborts expansion. When
//                             undefined the zeroize input is ignored.
// -----------------------------------------------------------------------------
module aes_key_sched_ctrl (
   input logic                 clk,
   input logic                 reset,
   aes_key_sched_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // One AES-128 round of key expansion: RotWord/SubWord/Rcon on w3 feeds w0,
   // then each following word chains off the freshly computed one.
   function automatic logic [127:0] expand_round(input logic [127:0] prev,
                                                 input logic [7:0]   rcon);
      logic [31:0] w0, w1, w2, w3, t;
      t  = sub_word({prev[23:0], prev[31:24]});
      w0 = prev[127:96] ^ t ^ {rcon, 24'h0};
      w1 = prev[95:64] ^ w0;
      w2 = prev[63:32] ^ w1;
      w3 = prev[31:0]  ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   state_t       r_state;
   state_t       w_state_nxt;
   logic [3:0]   r_round;
   logic [127:0] r_rk [0:10];
   logic [127:0] r_rk_out;
   logic         r_rk_out_valid;
   logic         r_rk_err;
   logic         r_keys_valid;

   logic         w_zeroize;
   logic         w_accept;
   logic         w_rd_legal;
   logic         w_key_ready;
   logic         w_busy;
   logic         w_done;
   logic [127:0] w_next_rk;

`ifdef AES_KEYSCHED_ZEROIZE_EN
   assign w_zeroize = bus.zeroize;
`else
   // Tied off: every zeroize path below folds away to nothing.
   assign w_zeroize = bus.zeroize & 1'b0;
`endif

   // Zeroize wins over a simultaneous key offer.
   assign w_accept   = bus.key_valid && (r_state == S_IDLE) && !w_zeroize;
   // keys_valid is only ever set in IDLE, so this also rejects reads while
   // expansion is running.
   assign w_rd_legal = bus.rk_rd && r_keys_valid && (bus.rk_idx <= 4'd10) && !w_zeroize;
   assign w_next_rk  = expand_round(r_rk[r_round - 4'd1], rcon_of(r_round));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_key_ready = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_key_ready = !w_zeroize;
            if (w_accept) w_state_nxt = S_EXPAND;
         end
         S_EXPAND: begin
            w_busy = 1'b1;
            if (r_round == 4'd10) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_done      = !w_zeroize;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_zeroize) w_state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_round        <= 4'd0;
         r_rk_out       <= '0;
         r_rk_out_valid <= 1'b0;
         r_rk_err       <= 1'b0;
         r_keys_valid   <= 1'b0;
         for (int i = 0; i < 11; i++) r_rk[i] <= '0;
      end else begin
         // Read port samples pre-edge storage, so a read in the same cycle as
         // key acceptance still returns the old key.
         r_rk_out_valid <= w_rd_legal;
         r_rk_err       <= bus.rk_rd && !w_rd_legal;
         if (w_rd_legal) begin
            r_rk_out <= r_rk[bus.rk_idx];
         end else if (bus.rk_rd) begin
            r_rk_out <= '0;
         end

         if (w_zeroize) begin
            r_round      <= 4'd0;
            r_rk_out     <= '0;
            r_keys_valid <= 1'b0;
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_rk[0]      <= bus.key_in;
                     r_keys_valid <= 1'b0;
                     r_round      <= 4'd1;
                  end
               end
               S_EXPAND: begin
                  r_rk[r_round] <= w_next_rk;
                  if (r_round != 4'd10) r_round <= r_round + 4'd1;
               end
               S_DONE: begin
                  r_keys_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.key_ready    = w_key_ready;
   assign bus.busy         = w_busy;
   assign bus.done         = w_done;
   assign bus.rk_out       = r_rk_out;
   assign bus.rk_out_valid = r_rk_out_valid;
   assign bus.rk_err       = r_rk_err;
   assign bus.keys_valid   = r_keys_valid;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
// Self-checking bench for aes_key_sched_ctrl: FIPS-197 vectors, read table,
// multi-cycle corner sequences and a randomized run against a reference model
// that expands keys with the word-array (w[0..43]) formulation and an S-box
// derived from GF(2^8) inversion.
// -----------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

`ifdef AES_KEYSCHED_ZEROIZE_EN
   localparam bit ZEN = 1'b1;
`else
   localparam bit ZEN = 1'b0;
`endif

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   aes_key_sched_ctrl_if bus();

   aes_key_sched_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   logic [7:0]   sbox_t [0:255];
   logic [127:0] m_rk [0:10];
   int           m_cnt;
   bit           m_kv, m_ov, m_err, m_ready, m_busy, m_done;
   logic [127:0] m_out;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) b = {b[6:0], b[7]};
      return b;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                     ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            t ^= {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Advance the model by one clock edge given this cycle's inputs.
   task automatic model_step(input bit rst_n, input bit zer, input bit kvld,
                             input logic [127:0] key, input bit rd, input logic [3:0] idx);
      bit z, legal;
      if (!rst_n) begin
         m_cnt = 0; m_kv = 0; m_ov = 0; m_err = 0; m_out = '0;
         for (int i = 0; i < 11; i++) m_rk[i] = '0;
      end else begin
         z     = ZEN && zer;
         legal = rd && m_kv && (idx <= 4'd10) && !z;
         m_ov  = legal;
         m_err = rd && !legal;
         if (legal) m_out = m_rk[idx];
         else if (rd) m_out = '0;
         if (z) begin
            m_cnt = 0; m_kv = 0; m_out = '0;
            for (int i = 0; i < 11; i++) m_rk[i] = '0;
         end else if (m_cnt == 0 && kvld) begin
            model_expand(key);
            m_kv  = 0;
            m_cnt = 11;
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) m_kv = 1;
         end
      end
      m_ready = (m_cnt == 0) && !(ZEN && zer);
      m_busy  = (m_cnt != 0);
      m_done  = (m_cnt == 1) && !(ZEN && zer);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic cycle(input bit rst_n, input bit zer, input bit kvld,
                        input logic [127:0] key, input bit rd, input logic [3:0] idx);
      reset         = rst_n;
      bus.zeroize   = zer;
      bus.key_valid = kvld;
      bus.key_in    = key;
      bus.rk_rd     = rd;
      bus.rk_idx    = idx;
      model_step(rst_n, zer, kvld, key, rd, idx);
      @(posedge clk); #1;
      chk("m_rk_out",     bus.rk_out,       m_out);
      chk("m_rk_valid",   bus.rk_out_valid, m_ov);
      chk("m_rk_err",     bus.rk_err,       m_err);
      chk("m_keys_valid", bus.keys_valid,   m_kv);
      chk("m_key_ready",  bus.key_ready,    m_ready);
      chk("m_busy",       bus.busy,         m_busy);
      chk("m_done",       bus.done,         m_done);
   endtask

   task automatic idle();
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 4'd0);
   endtask

   task automatic read(input logic [3:0] idx);
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, idx);
   endtask

   // Accept a key and wait (bounded) for done; done must land on cycle T+11,
   // i.e. on the 11th edge counting the accepting one.
   task automatic load_key(input logic [127:0] key, input string name);
      int n = -1;
      cycle(1'b1, 1'b0, 1'b1, key, 1'b0, 4'd0);
      for (int i = 2; i <= 22; i++) begin
         idle();
         if (bus.done === 1'b1) begin n = i; break; end
      end
      chk({name, "_done_lat"}, 128'(n), 128'(11));
      idle();
      chk({name, "_keys_valid"}, bus.keys_valid, 1'b1);
      chk({name, "_key_ready"},  bus.key_ready,  1'b1);
   endtask

   typedef struct {
      bit           rd;
      logic [3:0]   idx;
      bit           e_v;
      bit           e_err;
      logic [127:0] e_out;
   } rd_vec_t;

   rd_vec_t vec [8];

   initial begin
      int done_at;
      vec[0] = '{1'b1, 4'd1,  1'b1, 1'b0, FIPS_RK1};
      vec[1] = '{1'b1, 4'd10, 1'b1, 1'b0, FIPS_RK10};
      vec[2] = '{1'b1, 4'd0,  1'b1, 1'b0, FIPS_KEY};
      vec[3] = '{1'b0, 4'd3,  1'b0, 1'b0, FIPS_KEY};
      vec[4] = '{1'b1, 4'd11, 1'b0, 1'b1, 128'h0};
      vec[5] = '{1'b0, 4'd0,  1'b0, 1'b0, 128'h0};
      vec[6] = '{1'b1, 4'd15, 1'b0, 1'b1, 128'h0};
      vec[7] = '{1'b1, 4'd1,  1'b1, 1'b0, FIPS_RK1};

      reset = 1'b0; bus.zeroize = 1'b0; bus.key_valid = 1'b0; bus.key_in = '0;
      bus.rk_rd = 1'b0; bus.rk_idx = '0;
      build_sbox();

      // Reset state
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 4'd0);
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 4'd0);
      idle();
      chk("rst_key_ready",  bus.key_ready,  1'b1);
      chk("rst_keys_valid", bus.keys_valid, 1'b0);
      chk("rst_busy",       bus.busy,       1'b0);
      chk("rst_rk_out",     bus.rk_out,     128'h0);

      // Read before any key is loaded
      read(4'd0);
      chk("pre_key_err",   bus.rk_err,       1'b1);
      chk("pre_key_valid", bus.rk_out_valid, 1'b0);
      chk("pre_key_out",   bus.rk_out,       128'h0);

      // FIPS-197 load and read table (back-to-back)
      load_key(FIPS_KEY, "fips");
      foreach (vec[i]) begin
         cycle(1'b1, 1'b0, 1'b0, '0, vec[i].rd, vec[i].idx);
         chk($sformatf("tbl%0d_out", i),   bus.rk_out,       vec[i].e_out);
         chk($sformatf("tbl%0d_valid", i), bus.rk_out_valid, vec[i].e_v);
         chk($sformatf("tbl%0d_err", i),   bus.rk_err,       vec[i].e_err);
      end

      // Zero key offered while reading idx 0: read returns the old key.
      // Then hold an offer of the FIPS key through the whole expansion.
      cycle(1'b1, 1'b0, 1'b1, 128'h0, 1'b1, 4'd0);
      chk("same_cyc_out",   bus.rk_out,       FIPS_KEY);
      chk("same_cyc_valid", bus.rk_out_valid, 1'b1);
      chk("same_cyc_busy",  bus.busy,         1'b1);
      done_at = -1;
      for (int i = 1; i <= 11; i++) begin
         cycle(1'b1, 1'b0, 1'b1, FIPS_KEY, 1'b0, 4'd0);
         if (bus.done === 1'b1 && done_at < 0) done_at = i;
      end
      chk("held_done_at", 128'(done_at), 128'(10));
      chk("held_ready",   bus.key_ready, 1'b1);
      // Cycle T+12: read old idx 10 while the held offer is accepted
      cycle(1'b1, 1'b0, 1'b1, FIPS_KEY, 1'b1, 4'd10);
      chk("zero_rk10",     bus.rk_out, ZERO_RK10);
      chk("held_accepted", bus.busy,   1'b1);
      done_at = -1;
      for (int i = 2; i <= 22; i++) begin
         idle();
         if (bus.done === 1'b1) begin done_at = i; break; end
      end
      chk("reload_done_at", 128'(done_at), 128'(11));
      idle();
      read(4'd10);
      chk("reload_rk10", bus.rk_out, FIPS_RK10);

      // Reset in the middle of expansion (r = 5)
      cycle(1'b1, 1'b0, 1'b1, FIPS_KEY, 1'b0, 4'd0);
      for (int i = 0; i < 4; i++) idle();
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 4'd0);
      chk("midrst_keys_valid", bus.keys_valid, 1'b0);
      chk("midrst_key_ready",  bus.key_ready,  1'b1);
      chk("midrst_busy",       bus.busy,       1'b0);
      chk("midrst_rk_out",     bus.rk_out,     128'h0);
      read(4'd0);
      chk("midrst_read_err", bus.rk_err, 1'b1);
      load_key(FIPS_KEY, "after_rst");
      read(4'd1);
      chk("after_rst_rk1", bus.rk_out, FIPS_RK1);

      // Zeroize
`ifdef AES_KEYSCHED_ZEROIZE_EN
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, 4'd0);
      chk("zer_same_err", bus.rk_err,     1'b1);
      chk("zer_kv",       bus.keys_valid, 1'b0);
      chk("zer_ready",    bus.key_ready,  1'b0);
      read(4'd0);
      chk("zer_read_err", bus.rk_err, 1'b1);
      chk("zer_read_out", bus.rk_out, 128'h0);
      // Abort an expansion: no done pulse afterwards
      cycle(1'b1, 1'b0, 1'b1, FIPS_KEY, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) idle();
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b0, 4'd0);
      done_at = 0;
      for (int i = 0; i < 14; i++) begin
         idle();
         if (bus.done === 1'b1) done_at++;
      end
      chk("zer_abort_done", 128'(done_at), 128'(0));
      chk("zer_abort_kv",   bus.keys_valid, 1'b0);
`else
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, 4'd0);
      chk("nozer_read_out", bus.rk_out,     FIPS_KEY);
      chk("nozer_kv",       bus.keys_valid, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, 4'd10);
      chk("nozer_rk10",     bus.rk_out,     FIPS_RK10);
      chk("nozer_kv2",      bus.keys_valid, 1'b1);
`endif

      // Randomized run against the model
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 4'd0);
      for (int n = 0; n < 2000; n++) begin
         cycle($urandom_range(0, 199) != 0,
               ZEN ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 9) == 0),
               $urandom_range(0, 7) == 0,
               {$urandom, $urandom, $urandom, $urandom},
               $urandom_range(0, 1) == 1,
               4'($urandom_range(0, 12)));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
